// File: rtl/axi4lite_slave_regs.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit read/write registers to user logic.
// Independent write and read FSMs; all handshake outputs are registered.
module axi4lite_slave_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int NUM_REGS           = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [NUM_REGS*32-1:0]          reg_q,
  output logic [NUM_REGS-1:0]             reg_wr_pulse
);
  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int SW    = DW / 8;
  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t          r_wstate, w_wnext;
  rstate_t          r_rstate, w_rnext;
  logic             r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
  logic [1:0]       r_bresp, r_rresp;
  logic [DW-1:0]    r_rdata;
  logic [NUM_REGS-1:0] r_wr_pulse;
  logic [IDX_W-1:0] r_aw_idx;
  logic [DW-1:0]    r_wdata;
  logic [SW-1:0]    r_wstrb;
  logic [31:0]      r_regs [NUM_REGS];

  logic             w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_commit;
  logic [IDX_W-1:0] w_widx, w_ridx;
  logic [DW-1:0]    w_wdata, w_rd_word;
  logic [SW-1:0]    w_wstrb;
  logic             w_wr_ok, w_rd_ok;
  logic             w_unused;

  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign w_aw_hs = S_AXI_AWVALID && r_awready;
  assign w_w_hs  = S_AXI_WVALID  && r_wready;
  assign w_b_hs  = r_bvalid      && S_AXI_BREADY;
  assign w_ar_hs = S_AXI_ARVALID && r_arready;
  assign w_r_hs  = r_rvalid      && S_AXI_RREADY;

  // Commit uses whichever half arrives on this edge, else the captured copy.
  assign w_widx   = w_aw_hs ? S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2] : r_aw_idx;
  assign w_wdata  = w_w_hs  ? S_AXI_WDATA : r_wdata;
  assign w_wstrb  = w_w_hs  ? S_AXI_WSTRB : r_wstrb;
  assign w_wr_ok  = ({1'b0, w_widx} < (IDX_W+1)'(NUM_REGS));
  assign w_commit = (r_wstate != W_RESP) && (w_wnext == W_RESP);

  assign w_ridx   = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign w_rd_ok  = ({1'b0, w_ridx} < (IDX_W+1)'(NUM_REGS));

  always_comb begin
    w_wnext = r_wstate;
    case (r_wstate)
      W_IDLE: begin
        if (w_aw_hs && w_w_hs) w_wnext = W_RESP;
        else if (w_aw_hs)      w_wnext = W_HAVE_A;
        else if (w_w_hs)       w_wnext = W_HAVE_D;
      end
      W_HAVE_A: if (w_w_hs)  w_wnext = W_RESP;
      W_HAVE_D: if (w_aw_hs) w_wnext = W_RESP;
      W_RESP:   if (w_b_hs)  w_wnext = W_IDLE;
      default:  w_wnext = W_IDLE;
    endcase
  end

  always_comb begin
    w_rnext = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rnext = R_DATA;
      R_DATA:  if (w_r_hs)  w_rnext = R_IDLE;
      default: w_rnext = R_IDLE;
    endcase
  end

  always_comb begin
    w_rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (w_ridx == IDX_W'(i)) w_rd_word = r_regs[i];
  end

  // Write path: state, registered READY/VALID, register commit and pulse.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_wstate   <= W_IDLE;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bresp    <= 2'b00;
      r_wr_pulse <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_wstate   <= w_wnext;
      r_awready  <= (w_wnext == W_IDLE) || (w_wnext == W_HAVE_D);
      r_wready   <= (w_wnext == W_IDLE) || (w_wnext == W_HAVE_A);
      r_bvalid   <= (w_wnext == W_RESP);
      r_wr_pulse <= '0;
      if (w_commit) begin
        r_bresp <= w_wr_ok ? 2'b00 : 2'b10;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (w_wr_ok && (w_widx == IDX_W'(i))) begin
            r_wr_pulse[i] <= 1'b1;
            for (int b = 0; b < SW; b++)
              if (w_wstrb[b]) r_regs[i][8*b +: 8] <= w_wdata[8*b +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (w_aw_hs) r_aw_idx <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    if (w_w_hs) begin
      r_wdata <= S_AXI_WDATA;
      r_wstrb <= S_AXI_WSTRB;
    end
  end

  // Read path: data is sampled on the AR edge, so a same-edge write is not seen.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= 2'b00;
    end else begin
      r_rstate  <= w_rnext;
      r_arready <= (w_rnext == R_IDLE);
      r_rvalid  <= (w_rnext == R_DATA);
      if (w_ar_hs) begin
        r_rdata <= w_rd_word;
        r_rresp <= w_rd_ok ? 2'b00 : 2'b10;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_q
    assign reg_q[32*gi +: 32] = r_regs[gi];
  end

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;
  assign reg_wr_pulse  = r_wr_pulse;
endmodule

// File: doc/axi4lite_slave_regs.md
Name: axi4lite_slave_regs

Overview:
AXI4-Lite responder exposing NUM_REGS 32-bit read/write registers. It is the slave end of the S00_AXI interface that the AXI VIP master drives in our BD designs. It accepts single-beat writes and reads, with independent write and read FSMs. Register contents are exported to the user logic as a flat vector, with one write pulse per register.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 5, byte-address width; register index = addr[C_S_AXI_ADDR_WIDTH-1:2].
NUM_REGS, 4, number of implemented registers; must be ≤ 2^(C_S_AXI_ADDR_WIDTH-2).

Ports:
ACLK  in  1  clock.
ARESET  in  1  synchronous, active-high reset.
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
S_AXI_AWPROT  in  3  ignored.
S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  AW handshake.
S_AXI_WDATA  in  32  write data.
S_AXI_WSTRB  in  4  byte enables.
S_AXI_WVALID / S_AXI_WREADY  in / out  1  W handshake.
S_AXI_BRESP  out  2  write response (00 OKAY, 10 SLVERR).
S_AXI_BVALID / S_AXI_BREADY  out / in  1  B handshake.
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
S_AXI_ARPROT  in  3  ignored.
S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  AR handshake.
S_AXI_RDATA  out  32  read data.
S_AXI_RRESP  out  2  read response.
S_AXI_RVALID / S_AXI_RREADY  out / in  1  R handshake.
reg_q  out  NUM_REGS*32  register contents; reg i is at [32i+31:32i].
reg_wr_pulse  out  NUM_REGS  one-cycle pulse when reg i is written.

Behaviour:
- Reset (ARESET sampled high):
  - All registers = 0; all READY/VALID = 0; BRESP, RRESP, RDATA = 0; reg_wr_pulse = 0.
  - READY outputs are registered. They rise to 1 on the first rising edge with ARESET low, so the first post-reset cycle shows READY = 0.
- Reset mid-transaction: any partially captured AW/W is discarded with no register commit. Pending BVALID/RVALID drop on the next edge.
- Write FSM:
  - W_IDLE (AWREADY=1, WREADY=1):
    - AW and W both handshake on the same edge → W_RESP.
    - AW only → W_HAVE_A.
    - W only → W_HAVE_D.
  - W_HAVE_A (AWREADY=0, WREADY=1): W handshake → W_RESP.
  - W_HAVE_D (AWREADY=1, WREADY=0): AW handshake → W_RESP.
  - W_RESP (AWREADY=0, WREADY=0, BVALID=1): hold BVALID and BRESP stable until BREADY. On the B handshake edge → W_IDLE, with READYs = 1 in the following cycle.
- Write commit occurs on the edge entering W_RESP:
  - Per byte b, reg[idx][8b+7:8b] <= WDATA[8b+7:8b] if WSTRB[b].
  - reg_wr_pulse[idx] = 1 for exactly the first W_RESP cycle, even if WSTRB = 0.
  - idx ≥ NUM_REGS: no write, no pulse, BRESP = SLVERR.
  - AWADDR[1:0] is ignored.
- Read FSM:
  - R_IDLE (ARREADY=1): AR handshake → R_DATA.
  - R_DATA (ARREADY=0, RVALID=1): RDATA/RRESP are captured on the AR handshake edge and held stable until RREADY. The R handshake returns to R_IDLE.
  - idx ≥ NUM_REGS: RDATA = 0, RRESP = SLVERR.
- Latency and throughput: B and R are each valid in the cycle after their address/data acceptance. Minimum 2 cycles per write and 2 cycles per read.
- Read/write concurrency: the read and write FSMs are fully concurrent. If an AR handshake and a write commit hit the same register on the same edge, RDATA returns the pre-write value. A read accepted one cycle later returns the new value.
- Valid/ready rule: the slave never waits on an input READY before asserting its own VALID. BVALID and RVALID never deassert without a handshake, except on reset.

Test Plan:
- Sequential writes of 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, then reads of the same addresses → RDATA 1..4, all RRESP/BRESP = OKAY, reg_q = 0x00000004_00000003_00000002_00000001.
- reg0 = 0xAABBCCDD, then write 0x11223344 with WSTRB = 4'b0101 → read returns 0xAA22CC44; reg_wr_pulse[0] high for 1 cycle.
- W presented 3 cycles before AW (addr 0x8, data 0xDEADBEEF) → WREADY drops after the W handshake and AWREADY stays 1. BVALID appears the cycle after the AW handshake; reg2 = 0xDEADBEEF.
- Backpressure: BREADY and RREADY held low for 5 cycles → BVALID/RVALID and BRESP/RDATA stay stable. No new AW/AR is accepted until the handshake completes.
- Out of range: write to 0x10 then read 0x14 → BRESP = 2'b10 with no reg_q change; RRESP = 2'b10 with RDATA = 0.
- Same-edge AR and write commit on reg1 (old 0x5, new 0x9) → read returns 0x5, a subsequent read returns 0x9.
- Reset asserted while in W_HAVE_A → registers 0, BVALID 0, no pulse. READYs return to 1 on the second edge after deassertion.
